ram4x8_reader: RTL and testbench

Sequential read-out engine for the 4x8 register-file RAM. On a start pulse it snapshots the RAM's 32-bit parallel image and streams the four bytes, one per accepted transfer, over a valid/ready byte interface. Each byte is tagged with its address, and the engine keeps a running mod-256 checksum. It sits on the RAM's read side, downstream of the RAM output bus, and feeds display, serial or compare logic.

---
 rtl/ram4x8_reader_if.sv | 41 ++++
 rtl/ram4x8_reader.sv | 104 ++++++++++
 tb/tb_ram4x8_reader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram4x8_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : ram4x8_reader_if
// Description : Bus bundle between a ram4x8_reader and its environment.
//               Carries the start request, the RAM parallel image, the
//               valid/ready byte stream and the status outputs.
// Ports       : start     - read-out request (master -> reader)
//               mem_in    - 32-bit RAM image {word3..word0}
//               out_data  - streamed byte
//               out_addr  - address of out_data
//               out_valid - out_data/out_addr hold a byte
//               out_ready - sink accepts the byte (master -> reader)
//               busy      - reader is streaming
//               done      - one-cycle completion pulse
//               checksum  - mod-256 sum of transferred bytes
// Revision    : 1.0 - initial release
// ============================================================================
interface ram4x8_reader_if;
  logic        start;
  logic [31:0] mem_in;
  logic [7:0]  out_data;
  logic [1:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  // Environment side: requests read-outs and sinks the byte stream.
  modport master (
    output start, mem_in, out_ready,
    input  out_data, out_addr, out_valid, busy, done, checksum
  );

  // Reader side.
  modport slave (
    input  start, mem_in, out_ready,
    output out_data, out_addr, out_valid, busy, done, checksum
  );
endinterface
`default_nettype wire

// File: rtl/ram4x8_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram4x8_reader
// Description : Sequential read-out engine for the 4x8 register-file RAM.
//               On start it snapshots the RAM image and streams the four
//               bytes, tagged with their addresses, over a valid/ready
//               interface while accumulating a mod-256 checksum.
// Parameters  : WIDTH   - byte width (8)
//               DEPTH   - number of words (4)
//               REVERSE - 0: address 0..3, 1: address 3..0
// Ports       : CLK_    - system clock, rising edge
//               CLR     - synchronous active-high reset
//               if_bus  - ram4x8_reader_if.slave (start, mem_in, out_*,
//                         busy, done, checksum)
// Revision    : 1.0 - initial release
// ============================================================================
module ram4x8_reader #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int REVERSE = 0
) (
  input  wire logic          CLK_,
  input  wire logic          CLR,
  ram4x8_reader_if.slave     if_bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEND = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // First and last address of the stream depend on the direction.
  localparam logic [AW-1:0] c_FIRST = (REVERSE != 0) ? AW'(DEPTH - 1) : '0;
  localparam logic [AW-1:0] c_LAST  = (REVERSE != 0) ? '0 : AW'(DEPTH - 1);

  logic [1:0]             r_state;
  logic [WIDTH*DEPTH-1:0] r_snap;
  logic [AW-1:0]          r_idx;
  logic [WIDTH-1:0]       r_sum;

  logic [WIDTH-1:0]       w_bytes [DEPTH];
  logic                   w_send;
  logic [WIDTH-1:0]       w_cur;

  // Split the snapshot into addressable words.
  for (genvar g = 0; g < DEPTH; g++) begin : g_bytes
    assign w_bytes[g] = r_snap[g*WIDTH +: WIDTH];
  end

  assign w_send = (r_state == c_SEND);
  assign w_cur  = w_bytes[r_idx];

  always_ff @(posedge CLK_) begin
    if (CLR) begin
      r_state <= c_IDLE;
      r_snap  <= '0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (if_bus.start) begin
            r_snap  <= if_bus.mem_in;
            r_idx   <= c_FIRST;
            r_sum   <= '0;
            r_state <= c_SEND;
          end
        end
        c_SEND: begin
          if (if_bus.out_ready) begin
            r_sum <= r_sum + w_cur;
            // The index is left on the final address rather than wrapping;
            // it is invisible outside SEND anyway.
            if (r_idx == c_LAST) begin
              r_state <= c_DONE;
            end else if (REVERSE != 0) begin
              r_idx <= r_idx - AW'(1);
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Outputs are gated by registered state only, so out_ready and mem_in
  // never reach an output combinationally.
  assign if_bus.out_valid = w_send;
  assign if_bus.busy      = w_send;
  assign if_bus.done      = (r_state == c_DONE);
  assign if_bus.out_data  = w_send ? w_cur : '0;
  assign if_bus.out_addr  = w_send ? r_idx : '0;
  assign if_bus.checksum  = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_ram4x8_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram4x8_reader
// Description : Self-checking bench for ram4x8_reader. Drives a forward and
//               a reverse instance from shared stimulus and compares the
//               selected instance against table expectations and a
//               behavioural stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram4x8_reader;

  logic        CLK_ = 1'b0;
  logic        CLR;
  logic        r_start;
  logic [31:0] r_mem;
  logic        r_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK_ = ~CLK_;

  ram4x8_reader_if if0 ();
  ram4x8_reader_if if1 ();

  assign if0.start     = r_start;
  assign if0.mem_in    = r_mem;
  assign if0.out_ready = r_ready;
  assign if1.start     = r_start;
  assign if1.mem_in    = r_mem;
  assign if1.out_ready = r_ready;

  ram4x8_reader #(.WIDTH(8), .DEPTH(4), .REVERSE(0)) u_fwd (
    .CLK_   (CLK_),
    .CLR    (CLR),
    .if_bus (if0)
  );

  ram4x8_reader #(.WIDTH(8), .DEPTH(4), .REVERSE(1)) u_rev (
    .CLK_   (CLK_),
    .CLR    (CLR),
    .if_bus (if1)
  );

  // mode: 0 ready high, 1 random ready, 2 stall 3 cycles at addr 1,
  //       3 clear mem_in after capture, 4 start pulse at addr 2
  typedef struct {
    logic [31:0] img;
    bit          rev;
    int          mode;
    logic [31:0] seq;   // emitted bytes, first byte in [7:0]
    logic [7:0]  sum;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] g_data(input bit rev);
    return rev ? if1.out_data : if0.out_data;
  endfunction
  function automatic logic [1:0] g_addr(input bit rev);
    return rev ? if1.out_addr : if0.out_addr;
  endfunction
  function automatic logic g_valid(input bit rev);
    return rev ? if1.out_valid : if0.out_valid;
  endfunction
  function automatic logic g_busy(input bit rev);
    return rev ? if1.busy : if0.busy;
  endfunction
  function automatic logic g_done(input bit rev);
    return rev ? if1.done : if0.done;
  endfunction
  function automatic logic [7:0] g_sum(input bit rev);
    return rev ? if1.checksum : if0.checksum;
  endfunction

  // Reference: emission order is address order (or its reverse); each byte
  // is simply the addressed word of the image.
  function automatic logic [31:0] model_seq(input logic [31:0] img, input bit rev);
    logic [31:0] s;
    int a;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      a = rev ? 3 - k : k;
      s[8*k +: 8] = img[8*a +: 8];
    end
    return s;
  endfunction

  function automatic logic [7:0] model_sum(input logic [31:0] seq);
    int t;
    t = 0;
    for (int k = 0; k < 4; k++) t += int'(seq[8*k +: 8]);
    return 8'(t % 256);
  endfunction

  task automatic tick();
    @(posedge CLK_);
    #1;
  endtask

  task automatic check_idle(input string tag, input bit rev);
    chk({tag, " valid"}, 32'(g_valid(rev)), 32'd0);
    chk({tag, " busy"},  32'(g_busy(rev)),  32'd0);
    chk({tag, " data"},  32'(g_data(rev)),  32'd0);
    chk({tag, " addr"},  32'(g_addr(rev)),  32'd0);
  endtask

  task automatic run_stream(input logic [31:0] img, input bit rev, input int mode,
                            input logic [31:0] seq, input logic [7:0] sum);
    int k;
    int cycles;
    int stalls;
    int run_sum;
    logic [1:0] ea;
    k = 0; cycles = 0; stalls = 0; run_sum = 0;
    r_mem   = img;
    r_start = 1'b1;
    r_ready = 1'b1;
    tick();
    r_start = 1'b0;
    if (mode == 3) r_mem = 32'h0;
    while (k < 4 && cycles < 100) begin
      ea = rev ? 2'(3 - k) : 2'(k);
      chk("stream valid", 32'(g_valid(rev)), 32'd1);
      chk("stream busy",  32'(g_busy(rev)),  32'd1);
      chk("stream done",  32'(g_done(rev)),  32'd0);
      chk("stream addr",  32'(g_addr(rev)),  32'(ea));
      chk("stream data",  32'(g_data(rev)),  32'(seq[8*k +: 8]));
      chk("running sum",  32'(g_sum(rev)),   32'(run_sum % 256));
      case (mode)
        1: r_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (ea == 2'd1 && stalls < 3) begin
            r_ready = 1'b0;
            stalls++;
          end else begin
            r_ready = 1'b1;
          end
        end
        default: r_ready = 1'b1;
      endcase
      r_start = (mode == 4 && ea == 2'd2);
      tick();
      if (r_ready) begin
        run_sum += int'(seq[8*k +: 8]);
        k++;
      end
      cycles++;
    end
    r_start = 1'b0;
    if (k < 4) chk("stream timeout", 32'(k), 32'd4);
    chk("done pulse",  32'(g_done(rev)),  32'd1);
    chk("done valid",  32'(g_valid(rev)), 32'd0);
    chk("done busy",   32'(g_busy(rev)),  32'd0);
    chk("final sum",   32'(g_sum(rev)),   32'(sum));
    tick();
    chk("post done",   32'(g_done(rev)),  32'd0);
    check_idle("post", rev);
    chk("sum hold",    32'(g_sum(rev)),   32'(sum));
    if (mode == 4) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("no restart valid", 32'(g_valid(rev)), 32'd0);
        chk("no restart done",  32'(g_done(rev)),  32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] img;
    logic [31:0] seq;
    bit rev;

    vecs[0] = '{img: 32'h44332211, rev: 1'b0, mode: 0, seq: 32'h44332211, sum: 8'hAA};
    vecs[1] = '{img: 32'h44332211, rev: 1'b0, mode: 2, seq: 32'h44332211, sum: 8'hAA};
    vecs[2] = '{img: 32'hFF80FF80, rev: 1'b0, mode: 3, seq: 32'hFF80FF80, sum: 8'hFE};
    vecs[3] = '{img: 32'h44332211, rev: 1'b1, mode: 0, seq: 32'h11223344, sum: 8'hAA};
    vecs[4] = '{img: 32'h44332211, rev: 1'b0, mode: 4, seq: 32'h44332211, sum: 8'hAA};
    vecs[5] = '{img: 32'h01020304, rev: 1'b1, mode: 1, seq: 32'h04030201, sum: 8'h0A};
    vecs[6] = '{img: 32'hFFFFFFFF, rev: 1'b0, mode: 1, seq: 32'hFFFFFFFF, sum: 8'hFC};

    CLR = 1'b1; r_start = 1'b0; r_mem = 32'hDEADBEEF; r_ready = 1'b1;
    repeat (3) tick();
    for (int r = 0; r < 2; r++) begin
      check_idle("reset", bit'(r));
      chk("reset done", 32'(g_done(bit'(r))), 32'd0);
      chk("reset sum",  32'(g_sum(bit'(r))),  32'd0);
    end
    CLR = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_stream(vecs[i].img, vecs[i].rev, vecs[i].mode, vecs[i].seq, vecs[i].sum);
      tick();
    end

    // Reset after two transfers: stream aborted, no done, checksum lost.
    r_mem = 32'h44332211; r_ready = 1'b1; r_start = 1'b1;
    tick();
    r_start = 1'b0;
    tick();
    tick();
    chk("abort partial sum", 32'(if0.checksum), 32'h33);
    chk("abort addr",        32'(if0.out_addr), 32'd2);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check_idle("abort", 1'b0);
    chk("abort sum",  32'(if0.checksum), 32'd0);
    chk("abort done", 32'(if0.done),     32'd0);
    tick();
    chk("abort no done", 32'(if0.done),      32'd0);
    chk("abort idle",    32'(if0.out_valid), 32'd0);
    run_stream(32'h44332211, 1'b0, 0, 32'h44332211, 8'hAA);

    // Random images, direction and backpressure against the stream model.
    for (int t = 0; t < 20; t++) begin
      img = $urandom;
      rev = bit'($urandom_range(0, 1));
      seq = model_seq(img, rev);
      run_stream(img, rev, 1, seq, model_sum(seq));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
